// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and load/store (MEM).
// Optional build macro ARB_PERF_CNT_EN adds saturating conflict/wait performance counters.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16,
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          bus_err,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    dbg_state,
  output logic [SW-1:0] dbg_starve
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]   conflict_cnt,
  output logic [15:0]   wait_cnt
`endif
);

  // Handshake: a requester holds x_req (and its address/data) until it sees the
  // one-cycle x_ack pulse; the memory side holds mem_* stable while mem_req is high
  // and completes the access in any cycle where mem_ready is high.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [SW-1:0] starve_cnt;
  logic [7:0]    tmo_cnt;
  logic          if_m, d_m, conflict, force_if;
  logic          grant_if, grant_d, finish, abort;

  // A requester being acked this cycle is masked so it cannot be granted twice.
  assign if_m     = if_req & ~if_ack;
  assign d_m      = d_req & ~d_ack;
  assign conflict = if_m & d_m;
  assign force_if = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);

  assign stall_if   = reset & if_req & ~if_ack;
  assign stall_mem  = reset & d_req & ~d_ack;
  assign dbg_state  = state;
  assign dbg_starve = starve_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (if_m && (!d_m || force_if)) begin
          grant_if = 1'b1;
          state_n  = BUSY_IF;
        end else if (d_m) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready)                finish = 1'b1;
        else if (tmo_cnt == TMO_LAST) abort  = 1'b1;
        if (finish || abort) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      if (grant_if || grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= grant_d & d_we;
        mem_addr  <= grant_if ? if_addr : d_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
        tmo_cnt   <= '0;
      end
      // Only conflicts that IF loses count towards forcing an IF win.
      if (grant_if)
        starve_cnt <= '0;
      else if (grant_d && conflict && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SW'(1);
      if (state != IDLE && !finish && !abort)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (finish || abort) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        bus_err <= abort;
        if (state == BUSY_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= abort ? '0 : mem_rdata;
        end else begin
          d_ack <= 1'b1;
          if (abort)        d_rdata <= '0;
          else if (!mem_we) d_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
      wait_cnt     <= '0;
    end else begin
      if (state == IDLE && if_req && d_req && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
      if (state != IDLE && !mem_ready && wait_cnt != 16'hFFFF)
        wait_cnt <= wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences
// for starvation, timeout and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, bus_err, stall_if, stall_mem, mem_req, mem_we;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_starve;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  // Inputs applied for one cycle; e_stall_* hold before the edge, the rest after it.
  typedef struct {
    logic        if_req;  logic [31:0] if_addr;
    logic        d_req;   logic d_we; logic [31:0] d_addr; logic [31:0] d_wdata;
    logic        mem_ready; logic [31:0] mem_rdata;
    logic        e_stall_if; logic e_stall_mem;
    logic        e_mem_req; logic e_mem_we; logic [31:0] e_mem_addr; logic [31:0] e_mem_wdata;
    logic        e_if_ack; logic e_d_ack; logic [31:0] e_if_rdata; logic [31:0] e_d_rdata;
    logic        e_bus_err; logic [1:0] e_state;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // fetch 0x10
    vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
                 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd1};
    vecs[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0,
                 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2'd0};
    // conflict: load 0x40 wins, fetch 0x14 granted in the data ack cycle
    vecs[3]  = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1,
                 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2'd2};
    vecs[4]  = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hA5A50001, 1'b1, 1'b1,
                 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hA5A50001, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
                 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hA5A50001, 1'b0, 2'd1};
    vecs[6]  = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D, 1'b1, 1'b0,
                 1'b0, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0BADF00D, 32'hA5A50001, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0BADF00D, 32'hA5A50001, 1'b0, 2'd0};
    // store 0x80 <- 0x1234, two wait cycles; read data on the bus must not reach d_rdata
    vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234, 1'b0, 32'h0, 1'b0, 1'b1,
                 1'b1, 1'b1, 32'h80, 32'h1234, 1'b0, 1'b0, 32'h0BADF00D, 32'hA5A50001, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234, 1'b0, 32'h0, 1'b0, 1'b1,
                 1'b1, 1'b1, 32'h80, 32'h1234, 1'b0, 1'b0, 32'h0BADF00D, 32'hA5A50001, 1'b0, 2'd2};
    vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1,
                 1'b0, 1'b0, 32'h80, 32'h1234, 1'b0, 1'b1, 32'h0BADF00D, 32'hA5A50001, 1'b0, 2'd0};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h80, 32'h1234, 1'b0, 1'b0, 32'h0BADF00D, 32'hA5A50001, 1'b0, 2'd0};
    // mem_ready while idle
    vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77777777, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h80, 32'h1234, 1'b0, 1'b0, 32'h0BADF00D, 32'hA5A50001, 1'b0, 2'd0};

    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #12;
    check("rst_stall_if", 32'(stall_if), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_acks", 32'({if_ack, d_ack, bus_err}), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    if_req = 1'b0;
    step;
    reset = 1'b1;
    step;
    check("idle_state", 32'(dbg_state), 32'h0);
    check("idle_rdata", if_rdata | d_rdata, 32'h0);

    for (int i = 0; i < 13; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata; mem_ready = vecs[i].mem_ready; mem_rdata = vecs[i].mem_rdata;
      #1;
      check($sformatf("v%0d_stall_if", i), 32'(stall_if), 32'(vecs[i].e_stall_if));
      check($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(vecs[i].e_stall_mem));
      step;
      check($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_mem_req));
      check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_mem_we));
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      check($sformatf("v%0d_if_ack", i), 32'(if_ack), 32'(vecs[i].e_if_ack));
      check($sformatf("v%0d_d_ack", i), 32'(d_ack), 32'(vecs[i].e_d_ack));
      check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      check($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_d_rdata);
      check($sformatf("v%0d_bus_err", i), 32'(bus_err), 32'(vecs[i].e_bus_err));
      check($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_state));
    end
    mem_ready = 1'b0;

    // Starvation: IF withdraws after each loss so four consecutive conflicts can be built.
    for (int i = 0; i < 4; i++) begin
      if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0;
      d_addr = 32'h100 + 32'(i * 4); d_wdata = 32'h0;
      step;
      check($sformatf("starve%0d_state", i), 32'(dbg_state), 32'h2);
      check($sformatf("starve%0d_cnt", i), 32'(dbg_starve), 32'(i + 1));
      if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(i);
      step;
      check($sformatf("starve%0d_d_ack", i), 32'(d_ack), 32'h1);
      check($sformatf("starve%0d_d_rdata", i), d_rdata, 32'h1000 + 32'(i));
      mem_ready = 1'b0;
      step;
      check($sformatf("starve%0d_masked", i), 32'({mem_req, dbg_state}), 32'h0);
      d_req = 1'b0;
    end
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h110;
    step;
    check("starve5_if_wins", 32'(dbg_state), 32'h1);
    check("starve5_addr", mem_addr, 32'h20);
    check("starve5_cnt_clr", 32'(dbg_starve), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0000;
    step;
    check("starve5_if_ack", 32'(if_ack), 32'h1);
    check("starve5_if_rdata", if_rdata, 32'hCAFE0000);
    mem_ready = 1'b0;
    step;
    check("starve6_d_grant", 32'(dbg_state), 32'h2);
    check("starve6_addr", mem_addr, 32'h110);
    check("starve6_cnt", 32'(dbg_starve), 32'h0);
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1004;
    step;
    check("starve6_d_rdata", d_rdata, 32'h1004);
    mem_ready = 1'b0;
    step;
    d_req = 1'b0;

    // Timeout on a load, then a late mem_ready
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    step;
    check("tmo_grant", 32'(mem_req), 32'h1);
    for (int k = 0; k < 15; k++) begin
      step;
      check($sformatf("tmo_wait%0d", k), 32'({mem_req, d_ack}), 32'h2);
    end
    step;
    check("tmo_ack", 32'(d_ack), 32'h1);
    check("tmo_bus_err", 32'(bus_err), 32'h1);
    check("tmo_rdata", d_rdata, 32'h0);
    check("tmo_mem_req", 32'(mem_req), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h5555;
    step;
    check("tmo_late_ack", 32'({d_ack, bus_err}), 32'h0);
    check("tmo_late_rdata", d_rdata, 32'h0);
    check("tmo_late_state", 32'({mem_req, dbg_state}), 32'h0);
    d_req = 1'b0; mem_ready = 1'b0;
    step;

    // Reset in the middle of a load
    d_req = 1'b1; d_addr = 32'h300; mem_rdata = 32'h9999;
    step;
    check("rmid_busy", 32'({mem_req, dbg_state}), 32'h6);
    #2 reset = 1'b0;
    #1;
    check("rmid_mem_req", 32'(mem_req), 32'h0);
    check("rmid_state", 32'(dbg_state), 32'h0);
    check("rmid_stall_mem", 32'(stall_mem), 32'h0);
    mem_ready = 1'b1;
    step;
    step;
    check("rmid_hold", 32'({mem_req, d_ack}), 32'h0);
    reset = 1'b1; d_req = 1'b0; mem_ready = 1'b0;
    step;
    check("rmid_after_ack", 32'(d_ack), 32'h0);
    check("rmid_after_state", 32'({mem_req, dbg_state}), 32'h0);
    check("rmid_after_rdata", d_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
